hazard_stall_unit: RTL

- Producer-side companion to the forwarding logic. It tracks which register results are still unavailable and stalls ID when forwarding cannot resolve a dependency.
- Three cases stall: load-use, a branch comparing against an in-flight result, and an access to the destination of the multi-cycle mul/div unit.
- Sits beside the ID stage. It shadows the ID->EX->MEM write information internally and drives the PC/IF-ID hold and the ID->EX bubble.

---
 rtl/hazard_stall_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/hazard_stall_unit.sv
// Hazard stall unit: tracks in-flight results and stalls ID on load-use, branch-compare and mul/div hazards.
// Optional build macro HAZARD_STATS_EN adds saturating stall_cycles / md_stall_cycles counters.
`timescale 1ns/1ps
module hazard_stall_unit #(
  parameter int MULDIV_CYCLES = 4,
  parameter int REG_AW        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_op1,
  input  logic [REG_AW-1:0] id_op2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic [1:0]        id_regwrite,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_is_load,
  input  logic              id_is_branch,
  input  logic              id_is_muldiv,
  output logic              stall,
  output logic              md_busy,
  output logic [REG_AW-1:0] md_dest,
`ifdef HAZARD_STATS_EN
  output logic [15:0]       stall_cycles,
  output logic [15:0]       md_stall_cycles,
`endif
  output logic              md_done
);

  localparam int CW = 4;

  typedef enum logic {RUN, MD_BUSY} state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [REG_AW-1:0] r_md_dest, w_md_dest_nxt;

  logic              r_ex_vld, r_mem_vld;
  logic [REG_AW-1:0] r_ex_dest, r_mem_dest;
  logic              r_ex_wr, r_mem_wr, r_ex_ld, r_mem_ld;

  logic w_ex_hit, w_mem_hit, w_load_use, w_branch, w_md_done, w_md_block;
  logic w_stall, w_issue_md, w_ex_load_en;

  function automatic logic src_match(input logic use_bit, input logic vld, input logic wr,
                                     input logic [REG_AW-1:0] sh_dest,
                                     input logic [REG_AW-1:0] src);
    return use_bit & vld & wr & (sh_dest == src);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_ex_hit   = src_match(id_use1, r_ex_vld, r_ex_wr, r_ex_dest, id_op1) |
                      src_match(id_use2, r_ex_vld, r_ex_wr, r_ex_dest, id_op2);
  assign w_mem_hit  = src_match(id_use1, r_mem_vld, r_mem_wr, r_mem_dest, id_op1) |
                      src_match(id_use2, r_mem_vld, r_mem_wr, r_mem_dest, id_op2);
  assign w_load_use = w_ex_hit & r_ex_ld;
  assign w_branch   = id_is_branch & (w_ex_hit | (w_mem_hit & r_mem_ld));

  // The completion cycle releases dependents, so the mul/div block is off while md_done is high.
  assign w_md_done  = (r_state == MD_BUSY) && (r_cnt == '0);
  assign w_md_block = (r_state == MD_BUSY) & ~w_md_done &
                      ((id_use1 & (id_op1 == r_md_dest)) |
                       (id_use2 & (id_op2 == r_md_dest)) |
                       ((id_regwrite != 2'b00) & (id_dest == r_md_dest)) |
                       id_is_muldiv);

  assign w_stall      = id_valid & (w_load_use | w_branch | w_md_block);
  assign w_issue_md   = id_valid & id_is_muldiv & ~w_stall;
  assign w_ex_load_en = id_valid & ~w_stall & ~id_is_muldiv;

  assign stall   = w_stall;
  assign md_busy = (r_state == MD_BUSY);
  assign md_done = w_md_done;
  assign md_dest = r_md_dest;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_md_dest_nxt = r_md_dest;
    case (r_state)
      RUN: begin
        if (w_issue_md) begin
          w_state_nxt   = MD_BUSY;
          w_cnt_nxt     = CW'(MULDIV_CYCLES - 1);
          w_md_dest_nxt = id_dest;
        end
      end
      MD_BUSY: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (w_issue_md) begin
          w_cnt_nxt     = CW'(MULDIV_CYCLES - 1);
          w_md_dest_nxt = id_dest;
        end else begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // Control state: FSM, counter and shadow valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RUN;
      r_cnt     <= '0;
      r_md_dest <= '0;
      r_ex_vld  <= 1'b0;
      r_mem_vld <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_md_dest <= w_md_dest_nxt;
      r_ex_vld  <= w_ex_load_en;
      r_mem_vld <= r_ex_vld;
    end
  end

  // Shadow payload, only meaningful alongside its valid bit
  always_ff @(posedge clk) begin
    r_ex_dest  <= id_dest;
    r_ex_wr    <= (id_regwrite != 2'b00);
    r_ex_ld    <= id_is_load;
    r_mem_dest <= r_ex_dest;
    r_mem_wr   <= r_ex_wr;
    r_mem_ld   <= r_ex_ld;
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] r_stall_cycles, r_md_stall_cycles;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles    <= '0;
      r_md_stall_cycles <= '0;
    end else begin
      if (w_stall) r_stall_cycles <= sat_inc(r_stall_cycles);
      if (id_valid & w_md_block) r_md_stall_cycles <= sat_inc(r_md_stall_cycles);
    end
  end

  assign stall_cycles    = r_stall_cycles;
  assign md_stall_cycles = r_md_stall_cycles;
`endif

endmodule
